// File: rtl/td4_pkg.sv
// td4_pkg: shared TD4 input-stage types and constants (data width, data type, debounce FSM states)
package td4_pkg;
  localparam int TD4_DATA_W = 4;
  typedef logic [TD4_DATA_W-1:0] td4_data_t;
  typedef enum logic {DB_STABLE, DB_COUNTING} db_state_t;
endpackage

// File: rtl/td4_debounce_bit.sv
// td4_debounce_bit: one-bit two-flop synchroniser and debounce FSM; ports clk, rst (async high), sw raw level, q debounced level, chg/rise/fall one-cycle strobes (rise/fall only with TD4_IN_EDGE_EN)
module td4_debounce_bit
  import td4_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic q,
  output logic chg
`ifdef TD4_IN_EDGE_EN
  ,
  output logic rise,
  output logic fall
`endif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic sync1, sync2, diff, load;
  db_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= DB_STABLE;
      cnt   <= '0;
      q     <= 1'b0;
      chg   <= 1'b0;
`ifdef TD4_IN_EDGE_EN
      rise  <= 1'b0;
      fall  <= 1'b0;
`endif
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      state <= state_n;
      cnt   <= cnt_n;
      q     <= q ^ load;
      chg   <= load;
`ifdef TD4_IN_EDGE_EN
      rise  <= load & sync2;
      fall  <= load & ~sync2;
`endif
    end
  assign diff = sync2 != q;
  // a single-cycle qualification loads straight from STABLE, so COUNTING is never entered
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    if (state == DB_STABLE) begin
      if (diff && DEBOUNCE_CYCLES == 1) load = 1'b1;
      else if (diff) begin
        state_n = DB_COUNTING;
        cnt_n   = CW'(1);
      end
    end else if (!diff || cnt == LAST) begin
      load    = diff;
      state_n = DB_STABLE;
      cnt_n   = '0;
    end else cnt_n = cnt + CW'(1);
  end
endmodule

// File: rtl/td4_in_debounce.sv
// td4_in_debounce: synchronise and debounce WIDTH switch bits for the TD4 IN port; ports clk, rst (async high), sw_in raw, in_q debounced, chg any-bit change strobe, rise/fall per-bit edge strobes only with TD4_IN_EDGE_EN
module td4_in_debounce
  import td4_pkg::*;
#(
  parameter int WIDTH           = TD4_DATA_W,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] in_q,
  output logic             chg
`ifdef TD4_IN_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);
  logic [WIDTH-1:0] chg_b;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    td4_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
      .clk (clk),
      .rst (rst),
      .sw  (sw_in[i]),
      .q   (in_q[i]),
      .chg (chg_b[i])
`ifdef TD4_IN_EDGE_EN
      ,
      .rise(rise[i]),
      .fall(fall[i])
`endif
    );
  end
  // per-bit flags are registered, so the OR stays aligned with in_q
  assign chg = |chg_b;
endmodule

// File: tb/tb_td4_in_debounce.sv
// tb_td4_in_debounce: scoreboard bench for td4_in_debounce with DEBOUNCE_CYCLES=4
module tb_td4_in_debounce;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] sw_in = 4'b0000, in_q;
  logic chg;
`ifdef TD4_IN_EDGE_EN
  logic [3:0] rise, fall;
`endif
  td4_in_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .in_q(in_q), .chg(chg)
`ifdef TD4_IN_EDGE_EN
    , .rise(rise), .fall(fall)
`endif
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int at; logic [3:0] q; logic [3:0] r; logic [3:0] f;} exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0, errors = 0;
  logic [3:0] cur = 4'b0000;
  logic ok;
  // input driven now is first sampled at edge cyc+1, so in_q/chg appear at edge cyc+6
  task automatic push(input int lat, input logic [3:0] q, input logic [3:0] r, input logic [3:0] f);
    sb.push_back(exp_t'{cyc + lat, q, r, f});
  endtask
  task automatic apply(input logic [3:0] v, input logic [3:0] q, input logic [3:0] r, input logic [3:0] f);
    sw_in = v;
    push(6, q, r, f);
  endtask
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      cur = 4'b0000;
      if (in_q !== 4'b0000 || chg !== 1'b0) begin
        errors++;
        $display("FAIL reset: in_q=%b chg=%b, want in_q=0000 chg=0", in_q, chg);
      end
    end else begin
      if (chg === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_chg: cyc=%0d in_q=%b, want no change", cyc, in_q);
        end else begin
          e = sb.pop_front();
          ok = e.at == cyc && in_q === e.q;
`ifdef TD4_IN_EDGE_EN
          ok = ok && rise === e.r && fall === e.f;
          if (!ok) $display("FAIL chg_event: cyc=%0d in_q=%b rise=%b fall=%b, want cyc=%0d in_q=%b rise=%b fall=%b", cyc, in_q, rise, fall, e.at, e.q, e.r, e.f);
`else
          if (!ok) $display("FAIL chg_event: cyc=%0d in_q=%b, want cyc=%0d in_q=%b", cyc, in_q, e.at, e.q);
`endif
          if (!ok) errors++;
        end
        cur = in_q;
      end else begin
        checks++;
        ok = chg === 1'b0 && in_q === cur;
`ifdef TD4_IN_EDGE_EN
        ok = ok && rise === 4'b0000 && fall === 4'b0000;
`endif
        if (!ok) begin
          errors++;
          $display("FAIL hold: cyc=%0d in_q=%b chg=%b, want in_q=%b chg=0 with no strobes", cyc, in_q, chg, cur);
        end
      end
      if (sb.size() != 0 && cyc > sb[0].at) begin
        checks++;
        errors++;
        e = sb.pop_front();
        $display("FAIL missing_chg: cyc=%0d in_q=%b, want in_q=%b at cyc=%0d", cyc, in_q, e.q, e.at);
      end
    end
  end
  initial begin
    sw_in = 4'b1111;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    push(6, 4'b1111, 4'b1111, 4'b0000);
    repeat (10) @(negedge clk);
    apply(4'b0000, 4'b0000, 4'b0000, 4'b1111);
    repeat (10) @(negedge clk);
    apply(4'b0001, 4'b0001, 4'b0001, 4'b0000);
    repeat (10) @(negedge clk);
    sw_in = 4'b0101;
    repeat (3) @(negedge clk);
    sw_in = 4'b0001;
    repeat (10) @(negedge clk);
    apply(4'b0101, 4'b0101, 4'b0100, 4'b0000);
    repeat (4) @(negedge clk);
    apply(4'b0001, 4'b0001, 4'b0000, 4'b0100);
    repeat (10) @(negedge clk);
    apply(4'b0000, 4'b0000, 4'b0000, 4'b0001);
    repeat (10) @(negedge clk);
    apply(4'b1010, 4'b1010, 4'b1010, 4'b0000);
    repeat (10) @(negedge clk);
    apply(4'b0000, 4'b0000, 4'b0000, 4'b1010);
    repeat (10) @(negedge clk);
    sw_in = 4'b0100;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push(6, 4'b0100, 4'b0100, 4'b0000);
    repeat (10) @(negedge clk);
    apply(4'b0000, 4'b0000, 4'b0000, 4'b0100);
    repeat (10) @(negedge clk);
    apply(4'b0011, 4'b0011, 4'b0011, 4'b0000);
    repeat (10) @(negedge clk);
    apply(4'b0001, 4'b0001, 4'b0000, 4'b0010);
    repeat (12) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected changes never seen, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/td4_in_debounce.md
# td4_in_debounce

Input-conditioning stage placed directly upstream of the TD4 CPU core's 4-bit input port. It synchronises raw, asynchronous, bouncing switch inputs to `clk` and debounces each bit independently. It drives the clean 4-bit value the core reads with its IN instructions. It also raises a one-cycle change strobe, and can optionally provide per-bit edge strobes.

## Interface
- `WIDTH`, default 4: number of input bits; matches the core input port.
- `DEBOUNCE_CYCLES`, default 1000: consecutive `clk` cycles a synchronised bit must differ from its output before the output follows; legal range ≥ 1.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: reset, asynchronous and active-high.
- `sw_in`  input  WIDTH: raw switch levels, asynchronous to `clk`.
- `in_q`  output  WIDTH: debounced value; connects to the core `in` port.
- `chg`  output  1: high for one cycle when any `in_q` bit changes.
- `rise`  output  WIDTH: per-bit 0→1 strobe of `in_q`; present only with `TD4_IN_EDGE_EN`.
- `fall`  output  WIDTH: per-bit 1→0 strobe of `in_q`; present only with `TD4_IN_EDGE_EN`.

## Operation
- Per bit, a two-flop synchroniser: `sync1 <= sw_in[i]`, then `sync2 <= sync1`.
- Per-bit FSM with two states:
  - **STABLE**: counter is 0.
    - If `sync2 != in_q[i]` at an edge, go to COUNTING with counter = 1.
    - With `DEBOUNCE_CYCLES == 1`, toggle `in_q[i]` at that same edge and stay in STABLE instead.
  - **COUNTING**:
    - If `sync2 == in_q[i]` (bounce back), return to STABLE and clear the counter. `in_q` is unchanged.
    - Else if counter == `DEBOUNCE_CYCLES-1`, load `in_q[i] <= sync2`, clear the counter and return to STABLE.
    - Else increment the counter.
- Counter width is $clog2(DEBOUNCE_CYCLES+1). The counter never wraps, because the maximum stored value is `DEBOUNCE_CYCLES-1`.
- Bits are fully independent and may change on the same edge.
- `chg` is registered. It is the OR over bits of "`in_q[i]` loaded a new value at this edge", so it is high in exactly the cycle in which the new `in_q` is first visible.
- A glitch or bounce shorter than `DEBOUNCE_CYCLES` synchronised cycles never reaches `in_q`.

## Timing
- Reset values while `rst` is high: `sync1`, `sync2`, `in_q`, all counters, `chg`, `rise` and `fall` are 0, and every FSM is in STABLE. Reset takes effect immediately, without waiting for a clock edge.
- Latency for a clean input change: let edge k be the first edge at which `sync1` captures the new `sw_in` level. Then `in_q` and `chg` update at edge k+1+`DEBOUNCE_CYCLES`.
  - With `DEBOUNCE_CYCLES=4`, this is edge k+5.
- `chg`, `rise` and `fall` are each high for exactly one cycle per change event.
- Reset asserted mid-count abandons the count. After release, a held input is re-qualified from zero and follows the full latency above.
- After reset release with `sw_in` held at 1, `in_q` rises `DEBOUNCE_CYCLES`+1 cycles after the first sampling edge.

## Configuration
- Macro `TD4_IN_EDGE_EN`.
- Defined:
  - The `rise` and `fall` ports exist.
  - `rise[i]` is high in the cycle where `in_q[i]` becomes 1; `fall[i]` is high in the cycle where `in_q[i]` becomes 0.
  - Both are registered and aligned with `chg`.
- Undefined:
  - The ports and their logic are absent.
  - `in_q` and `chg` behaviour is identical to the defined case.

## Structure
- Shared package `td4_pkg`:
  - `TD4_DATA_W = 4`;
  - `td4_data_t` (logic [3:0]);
  - the per-bit FSM state enum `db_state_t` {`DB_STABLE`, `DB_COUNTING`}.
- Sub-module `td4_debounce_bit`:
  - contains the synchroniser, the FSM, the counter and the `in_q` bit, plus its change/rise/fall flags;
  - the top instantiates WIDTH copies in a generate loop and ORs the change flags into `chg`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `WIDTH=4`.
1. Reset: `rst`=1 with `sw_in`=4'b1111 → `in_q`=0, `chg`=0 throughout; after release, `in_q`=4'b1111 at edge k+5 with a single-cycle `chg`.
2. Clean step: `sw_in` 0000→0001, sampled at edge k → `in_q`=0001 at k+5, `chg`=1 only in that cycle, no other bit moves.
3. Bounce rejection: `sw_in[2]` pulses high for 3 cycles, then low → `in_q` stays 0000 and `chg` is never asserted. The same pulse held for 4 synchronised cycles → `in_q[2]`=1.
4. Simultaneous bits: `sw_in` 0000→1010 on one edge → both bits update on the same edge and `chg` pulses once. Return to 0000 → a single `chg` pulse.
5. Reset mid-count: `sw_in`=0100 and `rst` pulsed 2 cycles after sampling → `in_q` remains 0000; after release it goes to 0100 exactly 5 edges after the first post-reset sample.
6. With `TD4_IN_EDGE_EN`: `in_q` 0000→0011→0001 → `rise`=0011 in the first change cycle, then `fall`=0010 in the second change cycle, each high for one cycle and aligned with `chg`.
